// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor and the
// arithmetic blocks' testbenches.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 1-bit full subtractor, indexed by {x,y,bi}; each entry is {d,bo}
  localparam logic [7:0][1:0] FS_TABLE = '{
    2'b11,  // 111
    2'b00,  // 110
    2'b00,  // 101
    2'b10,  // 100
    2'b01,  // 011
    2'b11,  // 010
    2'b11,  // 001
    2'b00   // 000
  };

  localparam logic [1:0] FS_000 = 2'b00;
  localparam logic [1:0] FS_001 = 2'b11;
  localparam logic [1:0] FS_010 = 2'b11;
  localparam logic [1:0] FS_011 = 2'b01;
  localparam logic [1:0] FS_100 = 2'b10;
  localparam logic [1:0] FS_101 = 2'b00;
  localparam logic [1:0] FS_110 = 2'b00;
  localparam logic [1:0] FS_111 = 2'b11;

endpackage

// File: rtl/full_subtractor_case.sv
// Combinational 1-bit full subtractor: x - y - bi -> difference d, borrow bo.
module full_subtractor_case
  import sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  always_comb begin
    {d, bo} = FS_000;
    case ({x, y, bi})
      3'b000:  {d, bo} = FS_000;
      3'b001:  {d, bo} = FS_001;
      3'b010:  {d, bo} = FS_010;
      3'b011:  {d, bo} = FS_011;
      3'b100:  {d, bo} = FS_100;
      3'b101:  {d, bo} = FS_101;
      3'b110:  {d, bo} = FS_110;
      3'b111:  {d, bo} = FS_111;
      default: {d, bo} = FS_000;
    endcase
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, with valid/ready start and done
// handshakes. One result bit per clock through a single full subtractor.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         done_valid,
  input  logic         done_ready
);

  localparam int CW = $clog2(W + 1);

  state_t          state;
  logic [W-1:0]    sa, sb, res, res_nxt;
  logic            brw;
  logic [CW-1:0]   cnt;
  logic            d, bo, last;

  full_subtractor_case u_fs (
    .x  (sa[0]),
    .y  (sb[0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // result fills from the top so bit 0 lands in diff[0] after W shifts
  generate
    if (W == 1) begin : g_res1
      assign res_nxt = d;
    end else begin : g_resn
      assign res_nxt = {d, res[W-1:1]};
    end
  endgenerate

  assign last        = (cnt == CW'(W - 1));
  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            sa    <= a;
            sb    <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          brw <= bo;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          // outputs only change here, so diff never shows partial results
          if (last) begin
            diff  <= res_nxt;
            bout  <= bo;
            state <= DONE;
          end
        end
        DONE: begin
          if (done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at W=8 and W=1.
module tb_serial_subtractor;

  logic clk, rst_n;

  logic       sv8, sr8, bin8, dv8, bo8, dr8;
  logic [7:0] a8, b8, d8;
  logic       sv1, sr1, bin1, dv1, bo1, dr1;
  logic [0:0] a1, b1, d1;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .bin(bin8), .diff(d8), .bout(bo8),
    .done_valid(dv8), .done_ready(dr8)
  );

  serial_subtractor #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .bin(bin1), .diff(d1), .bout(bo1),
    .done_valid(dv1), .done_ready(dr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands for one cycle; returns at the negedge of the first
  // SHIFT cycle with the operand lines scrambled (they are don't-care now).
  task automatic start(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi);
    @(negedge clk);
    chk("start_ready_idle", (w == 8) ? sr8 : sr1, 1);
    if (w == 8) begin sv8 = 1'b1; a8 = a; b8 = b; bin8 = bi; end
    else        begin sv1 = 1'b1; a1 = a[0]; b1 = b[0]; bin1 = bi; end
    @(negedge clk);
    sv8 = 1'b0; sv1 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
  endtask

  // lat counts cycles after the accept cycle, the first SHIFT cycle being 1,
  // up to and including the first cycle with done_valid high (expect W+1).
  task automatic finish(input int w, input int lat0, input int hold,
                        output logic [7:0] d, output logic bo, output int lat);
    lat = lat0;
    while (!((w == 8) ? dv8 : dv1) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    d  = (w == 8) ? d8 : {7'b0, d1};
    bo = (w == 8) ? bo8 : bo1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_done_valid", (w == 8) ? dv8 : dv1, 1);
      chk("hold_diff", (w == 8) ? d8 : {7'b0, d1}, d);
      chk("hold_bout", (w == 8) ? bo8 : bo1, bo);
      chk("hold_start_ready", (w == 8) ? sr8 : sr1, 0);
    end
    if (w == 8) dr8 = 1'b1; else dr1 = 1'b1;
    @(negedge clk);
    dr8 = 1'b0; dr1 = 1'b0;
    chk("ack_done_valid_low", (w == 8) ? dv8 : dv1, 0);
    chk("ack_start_ready", (w == 8) ? sr8 : sr1, 1);
  endtask

  initial begin
    logic [7:0] d, ra, rb;
    logic       bo, rbi;
    logic [8:0] e8;
    logic [1:0] e1;
    int         lat;

    rst_n = 1'b0;
    sv8 = 0; a8 = 0; b8 = 0; bin8 = 0; dr8 = 0;
    sv1 = 0; a1 = 0; b1 = 0; bin1 = 0; dr1 = 0;
    #1;
    chk("rst_diff", d8, 0);
    chk("rst_bout", bo8, 0);
    chk("rst_done_valid", dv8, 0);
    chk("rst_start_ready", sr8, 1);
    chk("rst_w1_start_ready", sr1, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1: 0x5A - 0x3C = 0x1E
    start(8, 8'h5A, 8'h3C, 1'b0);
    finish(8, 1, 0, d, bo, lat);
    chk("t1_diff", d, 8'h1E);
    chk("t1_bout", bo, 0);
    chk("t1_latency", lat, 9);

    // T2: wrap-around, borrow out
    start(8, 8'h00, 8'h01, 1'b0);
    finish(8, 1, 0, d, bo, lat);
    chk("t2a_diff", d, 8'hFF);
    chk("t2a_bout", bo, 1);
    start(8, 8'h00, 8'h00, 1'b1);
    finish(8, 1, 0, d, bo, lat);
    chk("t2b_diff", d, 8'hFF);
    chk("t2b_bout", bo, 1);

    // T3: a start pulse mid-SHIFT must be ignored
    start(8, 8'h5A, 8'h3C, 1'b0);
    chk("t3_start_ready_busy", sr8, 0);
    sv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
    @(negedge clk);
    sv8 = 1'b0;
    finish(8, 2, 0, d, bo, lat);
    chk("t3_diff", d, 8'h1E);
    chk("t3_bout", bo, 0);
    chk("t3_latency", lat, 9);

    // T4: consumer stalls five cycles in DONE
    start(8, 8'hC3, 8'h42, 1'b1);
    finish(8, 1, 5, d, bo, lat);
    chk("t4_diff", d, 8'h80);
    chk("t4_bout", bo, 0);

    // T5: async reset in the 4th SHIFT cycle; diff still holds 0x80 before it
    start(8, 8'h77, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_mid_diff_unexposed", d8, 8'h80);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_diff", d8, 0);
    chk("t5_rst_bout", bo8, 0);
    chk("t5_rst_done_valid", dv8, 0);
    chk("t5_rst_start_ready", sr8, 1);
    @(negedge clk);
    rst_n = 1'b1;
    start(8, 8'h10, 8'h01, 1'b0);
    finish(8, 1, 0, d, bo, lat);
    chk("t5_diff", d, 8'h0F);
    chk("t5_bout", bo, 0);

    // T6: random operands against {bout,diff} = {0,a} - b - bin
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      e8 = {1'b0, ra} - {1'b0, rb} - {8'b0, rbi};
      start(8, ra, rb, rbi);
      finish(8, 1, 0, d, bo, lat);
      chk("t6_w8_diff", d, e8[7:0]);
      chk("t6_w8_bout", bo, e8[8]);
      chk("t6_w8_latency", lat, 9);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      e1 = {1'b0, ra[0]} - {1'b0, rb[0]} - {1'b0, rbi};
      start(1, ra, rb, rbi);
      finish(1, 1, 0, d, bo, lat);
      chk("t6_w1_diff", d, {7'b0, e1[0]});
      chk("t6_w1_bout", bo, e1[1]);
      chk("t6_w1_latency", lat, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
